// File: rtl/pb_debounce_pkg.sv
// Shared definitions for the push-button debouncer: one-hot state codes and
// the helpers that turn the counter width into debounce/hold/repeat intervals.
package pb_debounce_pkg;

   localparam int STATE_W = 7;

   localparam logic [STATE_W-1:0] ST_INI  = 7'b000_0001;
   localparam logic [STATE_W-1:0] ST_WQ   = 7'b000_0010;
   localparam logic [STATE_W-1:0] ST_SCEN = 7'b000_0100;
   localparam logic [STATE_W-1:0] ST_WH   = 7'b000_1000;
   localparam logic [STATE_W-1:0] ST_MCEN = 7'b001_0000;
   localparam logic [STATE_W-1:0] ST_CCR  = 7'b010_0000;
   localparam logic [STATE_W-1:0] ST_WFCR = 7'b100_0000;

   function automatic int unsigned t_db(input int unsigned n_dc);
      return 32'd1 << (n_dc - 32'd2);
   endfunction

   function automatic int unsigned t_hold(input int unsigned n_dc);
      return 32'd1 << (n_dc - 32'd1);
   endfunction

   function automatic int unsigned t_rep(input int unsigned n_dc);
      return 32'd1 << (n_dc - 32'd3);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/pb_debounce_enabler.sv
// Push-button debouncer producing a clean level plus single-step, auto-repeat
// and continuous enables; every output is a Moore decode of the FSM state.
module pb_debounce_enabler
   import pb_debounce_pkg::*;
#(
   parameter int N_DC = 25
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               PB,
   output logic               DPB,
   output logic               SCEN,
   output logic               MCEN,
   output logic               CCEN,
   output logic [STATE_W-1:0] state_dbg_o
);

   localparam logic [N_DC-1:0] DB_LAST   = N_DC'(t_db(N_DC) - 32'd1);
   localparam logic [N_DC-1:0] HOLD_LAST = N_DC'(t_hold(N_DC) - 32'd1);
   localparam logic [N_DC-1:0] REP_LAST  = N_DC'(t_rep(N_DC) - 32'd1);
   localparam logic [N_DC-1:0] CNT_ONE   = N_DC'(1);

   localparam logic [STATE_W-1:0] DPB_MASK  = ST_SCEN | ST_WH | ST_MCEN | ST_CCR | ST_WFCR;
   localparam logic [STATE_W-1:0] MCEN_MASK = ST_SCEN | ST_MCEN;
   localparam logic [STATE_W-1:0] CCEN_MASK = ST_SCEN | ST_MCEN | ST_CCR;

   logic               pb_s;
   logic [STATE_W-1:0] state_q, state_d;
   logic [N_DC-1:0]    cnt_q, cnt_d;

   sync_2ff u_sync (
      .clk_i (CLK),
      .rst_i (RESET),
      .d_i   (PB),
      .q_o   (pb_s)
   );

   // The counter restarts from zero on every state change.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_ONE;
      case (state_q)
         ST_INI: begin
            cnt_d = '0;
            if (pb_s) state_d = ST_WQ;
         end
         ST_WQ: begin
            if (!pb_s) begin
               state_d = ST_INI;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = ST_SCEN;
               cnt_d   = '0;
            end
         end
         ST_SCEN: begin
            state_d = ST_WH;
            cnt_d   = '0;
         end
         ST_WH: begin
            if (!pb_s) begin
               state_d = ST_WFCR;
               cnt_d   = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = ST_MCEN;
               cnt_d   = '0;
            end
         end
         ST_MCEN: begin
            state_d = ST_CCR;
            cnt_d   = '0;
         end
         ST_CCR: begin
            if (!pb_s) begin
               state_d = ST_WFCR;
               cnt_d   = '0;
            end else if (cnt_q == REP_LAST) begin
               state_d = ST_MCEN;
               cnt_d   = '0;
            end
         end
         ST_WFCR: begin
            // A bounce back to pressed restarts the release timer.
            if (pb_s) begin
               cnt_d = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = ST_INI;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_INI;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= ST_INI;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign DPB         = (state_q & DPB_MASK) != '0;
   assign SCEN        = state_q == ST_SCEN;
   assign MCEN        = (state_q & MCEN_MASK) != '0;
   assign CCEN        = (state_q & CCEN_MASK) != '0;
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_pb_debounce_enabler.sv
// Directed bench for pb_debounce_enabler at N_DC=5 (T_DB=8, T_HOLD=16, T_REP=4).
module tb_pb_debounce_enabler;
   import pb_debounce_pkg::*;

   logic               CLK;
   logic               RESET;
   logic               PB;
   logic               DPB;
   logic               SCEN;
   logic               MCEN;
   logic               CCEN;
   logic [STATE_W-1:0] state_dbg;

   int n_tests;
   int n_fail;

   pb_debounce_enabler #(.N_DC(5)) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .PB          (PB),
      .DPB         (DPB),
      .SCEN        (SCEN),
      .MCEN        (MCEN),
      .CCEN        (CCEN),
      .state_dbg_o (state_dbg)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Scenario ids: 1 short press, 2 bounce, 3 hold/repeat, 4 release bounce,
   // 5 reset mid-hold, 6 two presses. k = edge index, 1 = first edge with PB=1.
   function automatic logic pb_of(input int id, input int k);
      case (id)
         1: return k <= 15;
         2: return (k <= 3) || (k >= 7 && k <= 9);
         3: return k <= 45;
         4: return (k <= 15) || (k == 21);
         5: return k <= 44;
         6: return (k <= 15) || (k >= 28 && k <= 42);
         default: return 1'b0;
      endcase
   endfunction

   function automatic int len_of(input int id);
      case (id)
         1: return 32;
         2: return 25;
         3: return 62;
         4: return 40;
         5: return 62;
         6: return 60;
         default: return 0;
      endcase
   endfunction

   // Expected {DPB, SCEN, MCEN, CCEN} after edge k, hand-derived from the timeline.
   function automatic logic [3:0] exp_of(input int id, input int k);
      logic d, s, m, c;
      d = 1'b0; s = 1'b0; m = 1'b0; c = 1'b0;
      case (id)
         1: begin
            d = (k >= 11 && k <= 25);
            s = (k == 11); m = s; c = s;
         end
         3: begin
            d = (k >= 11 && k <= 55);
            s = (k == 11);
            m = (k == 11) || (k == 28) || (k == 33) || (k == 38) || (k == 43);
            c = (k == 11) || (k >= 28 && k <= 47);
         end
         4: begin
            d = (k >= 11 && k <= 30);
            s = (k == 11); m = s; c = s;
         end
         5: begin
            d = (k >= 11 && k <= 30) || (k >= 42 && k <= 54);
            s = (k == 11) || (k == 42);
            m = s || (k == 28);
            c = s || (k >= 28 && k <= 30);
         end
         6: begin
            d = (k >= 11 && k <= 25) || (k >= 38 && k <= 52);
            s = (k == 11) || (k == 38); m = s; c = s;
         end
         default: ;
      endcase
      return {d, s, m, c};
   endfunction

   // driver: set inputs away from the edge, then sample 1 time unit after it
   task automatic run_scn(input int id);
      for (int k = 1; k <= len_of(id); k++) begin
         PB    = pb_of(id, k);
         RESET = (id == 5) && (k == 31);
         @(posedge CLK);
         #1;
         check_eq($sformatf("s%0d_c%0d", id, k), {12'd0, DPB, SCEN, MCEN, CCEN}, {12'd0, exp_of(id, k)});
      end
      PB    = 1'b0;
      RESET = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      RESET   = 1'b1;
      PB      = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      check_eq("reset_outs", {12'd0, DPB, SCEN, MCEN, CCEN}, 16'd0);
      check_eq("reset_state", {9'd0, state_dbg}, {9'd0, ST_INI});
      PB    = 1'b0;
      RESET = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      check_eq("idle_state", {9'd0, state_dbg}, {9'd0, ST_INI});

      for (int id = 1; id <= 6; id++) begin
         run_scn(id);
         repeat (3) @(posedge CLK);
         #1;
         check_eq($sformatf("s%0d_end", id), {9'd0, state_dbg}, {9'd0, ST_INI});
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pb_debounce_enabler.md
Name: pb_debounce_enabler

Overview:
- Debounces one raw push-button input and produces the clean level and single-cycle enable pulses used by a core design on the full-speed board clock.
- Sits directly upstream of the divider core. Its SCEN output drives the core's single-step enable, so that one press gives exactly one compute step.
- Also provides multi-clock (auto-repeat) and continuous-clock enables for cores that need hold-to-repeat behaviour.

Parameters:
- N_DC, 25, width of the debounce counter. Derived intervals:
  - T_DB = 2^(N_DC-2) cycles: debounce time for both press and release.
  - T_HOLD = 2^(N_DC-1) cycles: hold time before auto-repeat starts.
  - T_REP = 2^(N_DC-3) cycles: auto-repeat period.
  - At 100 MHz with N_DC=25: 83.9 ms, 167.8 ms and 41.9 ms. Benches use N_DC=5, giving 8, 16 and 4 cycles.

Ports:
- CLK    in   1  board clock. All logic is on the rising edge.
- RESET  in   1  synchronous, active-high reset.
- PB     in   1  raw, asynchronous, bouncing button level (1 = pressed).
- DPB    out  1  debounced button level.
- SCEN   out  1  single-clock enable: one pulse per debounced press.
- MCEN   out  1  multi-clock enable: one pulse at press, then one every T_REP while held beyond T_HOLD.
- CCEN   out  1  continuous-clock enable: high every cycle while in the repeat region.

Behaviour:
- Synchroniser: PB passes through two flops to give pb_s. Latency is 2 edges. Only pb_s feeds the FSM.
- Counter: cnt[N_DC-1:0] is cleared on every state transition.
- All outputs are Moore decodes of the state (glitch-free).
- RESET (synchronous): at the next edge, state=INI, cnt=0, sync flops=0, so DPB=SCEN=MCEN=CCEN=0.
- Reset mid-operation aborts immediately. No pulse is emitted in the cycle after reset.
- State transitions:
  - INI: DPB=0. If pb_s=1, go to WQ.
  - WQ (qualify press):
    - pb_s=0: go to INI (bounce rejected).
    - cnt==T_DB-1: go to SCEN_ST.
    - otherwise: cnt++.
  - SCEN_ST: one cycle with SCEN=MCEN=CCEN=DPB=1. Unconditionally go to WH.
  - WH (wait hold):
    - pb_s=0: go to WFCR.
    - cnt==T_HOLD-1: go to MCEN_ST.
    - otherwise: cnt++.
  - MCEN_ST: one cycle with MCEN=CCEN=DPB=1. Unconditionally go to CCR.
  - CCR (repeat):
    - CCEN=DPB=1.
    - pb_s=0: go to WFCR.
    - cnt==T_REP-1: go to MCEN_ST.
    - otherwise: cnt++.
  - WFCR (qualify release):
    - DPB=1.
    - pb_s=1: cnt=0 and stay (release bounce restarts the timer).
    - cnt==T_DB-1: go to INI.
    - otherwise: cnt++.
- DPB=1 exactly in SCEN_ST, WH, MCEN_ST, CCR and WFCR.
- SCEN is asserted at most once per qualified press. A new SCEN requires a full return through WFCR to INI.
- Priority in WH/CCR when a release coincides with cnt terminal: release wins, go to WFCR, no MCEN.
- PB=1 held through reset deassertion: a normal press is qualified from INI, giving a full T_DB delay.
- Latency to first pulse: SCEN is high in the (T_DB+3)th cycle after the first edge that samples PB=1. This is 11 cycles at N_DC=5.

Decomposition:
- Package pb_debounce_pkg holds:
  - the state enum (INI, WQ, SCEN_ST, WH, MCEN_ST, CCR, WFCR), one-hot encoded;
  - the functions deriving T_DB, T_HOLD and T_REP from N_DC.
- One sub-module, sync_2ff: the two-flop synchroniser with synchronous reset to 0.
- The FSM and counter stay in pb_debounce_enabler.

Test Plan (N_DC=5, cycle 1 = first edge sampling PB=1):
- Short press: PB=1 for cycles 1-15, then 0.
  - SCEN=MCEN=CCEN=1 only in cycle 11.
  - DPB rises in cycle 11 and falls 8 cycles after pb_s drops (cycle 26).
  - No further MCEN.
- Bounce rejection: PB toggles 1,0,1,0 with runs of 3 cycles, then 0. All outputs stay 0 throughout.
- Hold/auto-repeat: PB=1 for 45 cycles.
  - SCEN only at cycle 11.
  - MCEN at cycles 11, 28, 33, 38, 43.
  - CCEN high continuously from 28 until release is detected.
- Release bounce: after a qualified press, PB returns 0 for 5 cycles, 1 for 1 cycle, then 0.
  - DPB stays 1 until 8 clean low cycles have elapsed.
  - No second SCEN.
- Reset mid-hold: assert RESET at cycle 30 of a hold.
  - All outputs are 0 from cycle 31.
  - After RESET deasserts with PB still 1, SCEN recurs exactly T_DB+3 cycles later.
- Two presses separated by 12 low cycles: exactly two SCEN pulses, one per press.
